lcd_bus_sched: RTL and testbench
================================

LCD_BUS_SCHED -- requirements
Module: lcd_bus_sched

Interface
REQ-001 Parameter DIV, 5, clk cycles per timing tick (>=2).
REQ-002 Parameter INIT_TICKS, 70, power-up wait in ticks before first command.
REQ-003 Parameter SLOW_TICKS, 200, extra wait in ticks after clear (0x01) or home (0x02) command.
REQ-004 clk  in  1  system clock; one clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 req0 / req1  in  1  write request from requester 0 / 1.
REQ-007 rs0 / rs1  in  1  register select of request (0 command, 1 character).
REQ-008 data0 / data1  in  8  byte to write.
REQ-009 ack0 / ack1  out  1  one-clock pulse; request accepted and latched.
REQ-010 ready  out  1  init complete and scheduler idle.
REQ-011 lcd_e  out  1  LCD enable strobe.
REQ-012 lcd_rs  out  1  LCD register select.
REQ-013 lcd_rw  out  1  LCD read/write; constant 0 (write only).
REQ-014 lcd_data  out  8  LCD data bus.

Function
REQ-015 Tick: one-clock pulse every DIV clocks; counter restarts at reset; all state transitions occur only on tick cycles.
REQ-016 States: INIT_WAIT, INIT_CMD, IDLE, SETUP, E_HI, HOLD, BUSY_WAIT.
REQ-017 INIT_WAIT: count INIT_TICKS ticks -> INIT_CMD.
REQ-018 INIT_CMD: issue in order 0x3C, 0x0C, 0x06, 0x01 (rs=0), each via SETUP/E_HI/HOLD; after last command and its BUSY_WAIT -> IDLE.
REQ-019 IDLE on tick: if any req, grant one, latch its rs/data, pulse its ack that same clock, -> SETUP; no req -> stay.
REQ-020 Arbitration: single requester granted directly; both asserted -> grant the port not granted last; last-grant reset to port 1 so port 0 wins first tie.
REQ-021 Requester holds req/rs/data stable until ack; dropping req before ack withdraws it; req outside IDLE waits, no ack.
REQ-022 SETUP: lcd_rs/lcd_data driven from latch, lcd_e=0; next tick -> E_HI.
REQ-023 E_HI: lcd_e=1 for exactly DIV clocks, bus stable; next tick -> HOLD.
REQ-024 HOLD: lcd_e=0, bus stable; next tick -> BUSY_WAIT if latched rs=0 and data 0x01 or 0x02, else IDLE.
REQ-025 BUSY_WAIT: count SLOW_TICKS ticks -> IDLE (or next INIT_CMD during init).
REQ-026 Fast write: ack to next possible ack = 4 ticks; slow write = 4+SLOW_TICKS ticks.
REQ-027 ready=1 only in IDLE after init; 0 in every other state and during init.
REQ-028 lcd_data/lcd_rs hold last written values in IDLE and BUSY_WAIT.
REQ-029 ack0 and ack1 never asserted together; at most one ack per tick.

Reset
REQ-030 rst low on a clock edge: next cycle lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, ack0=ack1=0, ready=0, state INIT_WAIT, tick counter 0, last-grant port 1.
REQ-031 Reset mid-transfer (any state) aborts it; lcd_e drops next clock; the in-flight request is not re-issued; full init repeats.

Structure
REQ-032 Package lcd_pkg: command constants (0x3C, 0x0C, 0x06, 0x01, 0x02, line addresses 0x80/0xC0), character constants (digits 0x30-0x39, '+', '-', '=', blank 0x20), state encoding.
REQ-033 One sub-module lcd_tick_gen: DIV-cycle tick pulse generator with synchronous active-low reset.

Verification (DIV=2, INIT_TICKS=4, SLOW_TICKS=3 unless noted)
REQ-034 Release reset, no requests -> lcd_e pulses with data 0x3C,0x0C,0x06,0x01 in order, rs=0, each lcd_e high 2 clocks; ready rises 3 ticks after the 0x01 HOLD ends.
REQ-035 After ready, req0 rs=1 data=0x35 -> ack0 one clock on next tick; one lcd_e pulse with rs=1, data 0x35; ready low 4 ticks.
REQ-036 req0 and req1 asserted together continuously (0x31, 0x32) -> acks alternate 0,1,0,1; writes appear 0x31,0x32,0x31,0x32.
REQ-037 req1 rs=0 data=0x01 -> after HOLD, ready stays low 3 extra ticks; req0 raised meanwhile acked only after BUSY_WAIT.
REQ-038 rst low during E_HI of a write -> next clock lcd_e=0, lcd_data=0x00, ready=0; init sequence 0x3C... restarts; aborted request never re-driven.
REQ-039 req0 pulsed high for 1 clock between ticks in IDLE -> no ack, no lcd_e pulse.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780-style command/character constants and scheduler state encoding.
package lcd_pkg;
   localparam logic [7:0] CMD_FUNC_SET = 8'h3C;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;
   localparam logic [7:0] CH_DIGIT0    = 8'h30;
   localparam logic [7:0] CH_DIGIT9    = 8'h39;
   localparam logic [7:0] CH_PLUS      = 8'h2B;
   localparam logic [7:0] CH_MINUS     = 8'h2D;
   localparam logic [7:0] CH_EQUAL     = 8'h3D;
   localparam logic [7:0] CH_BLANK     = 8'h20;
   typedef enum logic [2:0] {
      ST_INIT_WAIT,
      ST_INIT_CMD,
      ST_IDLE,
      ST_SETUP,
      ST_E_HI,
      ST_HOLD,
      ST_BUSY_WAIT
   } state_e;
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      return idx == 2'd0 ? CMD_FUNC_SET : idx == 2'd1 ? CMD_DISP_ON : idx == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
   endfunction
   // clear and home need the long busy time of the controller
   function automatic logic is_slow(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME);
   endfunction
endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: one-clock tick pulse every DIV clocks, counter restarts on reset.
module lcd_tick_gen #(
   parameter int DIV = 5
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      tick_o = cnt_q == CW'(DIV - 1);
      cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: two-port write arbiter and timing sequencer for a write-only character LCD,
// including the power-up init command sequence.
module lcd_bus_sched
   import lcd_pkg::*;
#(
   parameter int DIV        = 5,
   parameter int INIT_TICKS = 70,
   parameter int SLOW_TICKS = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       ready,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);
   localparam int WMAX = INIT_TICKS > SLOW_TICKS ? INIT_TICKS : SLOW_TICKS;
   localparam int WW   = $clog2(WMAX + 1);
   state_e        state_q, state_d, nxt_st;
   logic [WW-1:0] wait_q, wait_d;
   logic [1:0]    idx_q, idx_d;
   logic          init_q, init_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          last_q, last_d;
   logic          tick, any_req, gnt, go, slow, wait_done, counting, fin;
   lcd_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_INIT_WAIT;
         wait_q  <= '0;
         idx_q   <= '0;
         init_q  <= 1'b1;
         rs_q    <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end
   // on a tie the port that lost last time wins; a lone request is granted directly
   always_comb begin
      any_req   = req0 | req1;
      gnt       = (req0 & req1) ? ~last_q : req1;
      go        = state_q == ST_IDLE && tick && any_req;
      slow      = is_slow(rs_q, data_q);
      wait_done = state_q == ST_INIT_WAIT ? wait_q == WW'(INIT_TICKS - 1) : wait_q == WW'(SLOW_TICKS - 1);
      nxt_st    = init_q && idx_q != 2'd3 ? ST_INIT_CMD : ST_IDLE;
   end
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            ST_INIT_WAIT: if (wait_done) state_d = ST_INIT_CMD;
            ST_INIT_CMD:  state_d = ST_SETUP;
            ST_IDLE:      if (any_req) state_d = ST_SETUP;
            ST_SETUP:     state_d = ST_E_HI;
            ST_E_HI:      state_d = ST_HOLD;
            ST_HOLD:      state_d = slow ? ST_BUSY_WAIT : nxt_st;
            ST_BUSY_WAIT: if (wait_done) state_d = nxt_st;
            default:      state_d = ST_INIT_WAIT;
         endcase
      end
   end
   // fin marks the tick on which a command has fully completed (including any busy wait)
   always_comb begin
      counting = state_q == ST_INIT_WAIT || state_q == ST_BUSY_WAIT;
      fin      = tick && ((state_q == ST_HOLD && !slow) || (state_q == ST_BUSY_WAIT && wait_done));
      wait_d   = !counting ? '0 : !tick ? wait_q : wait_done ? '0 : wait_q + 1'b1;
      idx_d    = fin && init_q ? idx_q + 2'd1 : idx_q;
      init_d   = fin && init_q && idx_q == 2'd3 ? 1'b0 : init_q;
      rs_d     = go ? (gnt ? rs1 : rs0) : (tick && state_q == ST_INIT_CMD) ? 1'b0 : rs_q;
      data_d   = go ? (gnt ? data1 : data0) : (tick && state_q == ST_INIT_CMD) ? init_cmd(idx_q) : data_q;
      last_d   = go ? gnt : last_q;
   end
   always_comb begin
      ack0     = go & ~gnt;
      ack1     = go & gnt;
      ready    = state_q == ST_IDLE;
      lcd_e    = state_q == ST_E_HI;
      lcd_rs   = rs_q;
      lcd_rw   = 1'b0;
      lcd_data = data_q;
   end
endmodule

// File: tb/tb_lcd_bus_sched.sv
// tb_lcd_bus_sched: directed bench for lcd_bus_sched with DIV=2, INIT_TICKS=4, SLOW_TICKS=3.
module tb_lcd_bus_sched;
   logic       clk, rst, req0, req1, rs0, rs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, ready, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;
   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int lastfall = 0;
   int both_err = 0;
   int rw_err = 0;
   int unstab = 0;
   logic       e_prev = 1'b0;
   logic [7:0] cd = 8'h00;
   logic       crs = 1'b0;
   int         w = 0;
   logic [7:0] pd[$];
   logic       prs[$];
   int         pw[$];
   lcd_bus_sched #(.DIV(2), .INIT_TICKS(4), .SLOW_TICKS(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .rs0      (rs0),
      .rs1      (rs1),
      .data0    (data0),
      .data1    (data1),
      .ack0     (ack0),
      .ack1     (ack1),
      .ready    (ready),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // records every lcd_e pulse (data, rs, width in clocks) and flags protocol violations
   always @(negedge clk) begin
      if (lcd_e) begin
         if (!e_prev) begin
            cd = lcd_data;
            crs = lcd_rs;
            w = 0;
         end
         w++;
         if (lcd_data !== cd || lcd_rs !== crs) unstab++;
      end else if (e_prev) begin
         pd.push_back(cd);
         prs.push_back(crs);
         pw.push_back(w);
         lastfall = cyc;
      end
      e_prev = lcd_e;
      if (ack0 && ack1) both_err++;
      if (lcd_rw !== 1'b0) rw_err++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // which: 0 ready, 1 ack0, 2 ack1, 3 lcd_e, 4 any ack
   task automatic wait_sig(input string tag, input int which, input int lim, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < lim) begin
         @(negedge clk);
         n++;
         hit = which == 0 ? ready : which == 1 ? ack0 : which == 2 ? ack1 : which == 3 ? lcd_e : (ack0 | ack1);
      end
      if (!hit) chk({tag, "_timeout"}, 0, 1);
   endtask
   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      logic [7:0] init_exp[4];
      logic [7:0] tie_exp[4];
      int n, s, c1, prev;
      logic acc, allrdy;
      init_exp = '{8'h3C, 8'h0C, 8'h06, 8'h01};
      tie_exp = '{8'h31, 8'h32, 8'h31, 8'h32};
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_e", 32'(lcd_e), 0);
      chk("rst_rs", 32'(lcd_rs), 0);
      chk("rst_rw", 32'(lcd_rw), 0);
      chk("rst_data", 32'(lcd_data), 0);
      chk("rst_ack", 32'({ack0, ack1}), 0);
      chk("rst_ready", 32'(ready), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      wait_sig("init_ready", 0, 400, n);
      chk("init_cnt", 32'(pd.size()), 4);
      for (int i = 0; i < 4; i++) begin
         chk("init_data", 32'(pd[i]), 32'(init_exp[i]));
         chk("init_rs", 32'(prs[i]), 0);
         chk("init_ewidth", 32'(pw[i]), 2);
      end
      chk("init_ready_delay", 32'(cyc - lastfall), 8);
      s = pd.size();
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h31;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h32;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_sig("tie_ack", 4, 40, n);
         chk("tie_who", 32'(ack1), 32'(k % 2));
         if (k > 0) chk("tie_ack_gap", 32'(cyc - prev), 8);
         prev = cyc;
      end
      @(posedge clk);
      #1 req0 = 1'b0; req1 = 1'b0;
      wait_sig("tie_ready", 0, 40, n);
      for (int i = 0; i < 4; i++) chk("tie_data", 32'(pd[s + i]), 32'(tie_exp[i]));
      s = pd.size();
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h35;
      wait_sig("one_ack", 1, 40, n);
      chk("one_ack1_quiet", 32'(ack1), 0);
      @(posedge clk);
      #1 req0 = 1'b0;
      @(negedge clk);
      chk("one_ack_1clk", 32'(ack0), 0);
      chk("one_ready_low", 32'(ready), 0);
      wait_sig("one_ready", 0, 40, n);
      chk("one_busy_clks", 32'(n), 6);
      chk("one_cnt", 32'(pd.size() - s), 1);
      chk("one_data", 32'(pd[s]), 32'h35);
      chk("one_rs", 32'(prs[s]), 1);
      chk("one_ewidth", 32'(pw[s]), 2);
      s = pd.size();
      req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
      wait_sig("slow_ack1", 2, 40, n);
      c1 = cyc;
      @(posedge clk);
      #1 req1 = 1'b0; req0 = 1'b1; rs0 = 1'b1; data0 = 8'h36;
      wait_sig("slow_ack0", 1, 60, n);
      chk("slow_ack_gap", 32'(cyc - c1), 14);
      chk("slow_hold_data", 32'(lcd_data), 32'h01);
      chk("slow_hold_rs", 32'(lcd_rs), 0);
      @(posedge clk);
      #1 req0 = 1'b0;
      wait_sig("slow_ready", 0, 40, n);
      chk("slow_data0", 32'(pd[s]), 32'h01);
      chk("slow_data1", 32'(pd[s + 1]), 32'h36);
      chk("slow_rs1", 32'(prs[s + 1]), 1);
      s = pd.size();
      @(posedge clk);
      @(posedge clk);
      #1 req0 = 1'b1; rs0 = 1'b1; data0 = 8'h38;
      @(posedge clk);
      #1 req0 = 1'b0;
      acc = 1'b0;
      allrdy = 1'b1;
      repeat (20) begin
         @(negedge clk);
         acc |= ack0 | ack1;
         allrdy &= ready;
      end
      chk("glitch_ack", 32'(acc), 0);
      chk("glitch_ready", 32'(allrdy), 1);
      chk("glitch_pulse", 32'(pd.size() - s), 0);
      s = pd.size();
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h37;
      wait_sig("abort_ack", 1, 40, n);
      @(posedge clk);
      #1 req0 = 1'b0;
      wait_sig("abort_e", 3, 20, n);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_e_low", 32'(lcd_e), 0);
      chk("abort_data", 32'(lcd_data), 0);
      chk("abort_rs", 32'(lcd_rs), 0);
      chk("abort_ready", 32'(ready), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      wait_sig("abort_ready", 0, 400, n);
      repeat (20) @(negedge clk);
      chk("abort_cnt", 32'(pd.size() - s), 5);
      chk("abort_width", 32'(pw[s]), 1);
      for (int i = 0; i < 4; i++) chk("reinit_data", 32'(pd[s + 1 + i]), 32'(init_exp[i]));
      chk("ack_exclusive", 32'(both_err), 0);
      chk("rw_zero", 32'(rw_err), 0);
      chk("bus_stable", 32'(unstab), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
